// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path: character-length
// encodings, default widths and the frame-length function.
package uart_pkg;

    localparam int UART_DATA_MAX = 8;
    localparam int UART_CNT_W    = 4;

    localparam logic [1:0] CL_5 = 2'b00;
    localparam logic [1:0] CL_6 = 2'b01;
    localparam logic [1:0] CL_7 = 2'b10;
    localparam logic [1:0] CL_8 = 2'b11;

    // Data bits plus optional parity plus one stop bit.
    function automatic logic [UART_CNT_W-1:0] frame_len(input logic [1:0] char_len,
                                                        input logic       parity_en);
        return UART_CNT_W'(5) + UART_CNT_W'(char_len) + UART_CNT_W'(parity_en)
               + UART_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_receive_datapath_if.sv
// Character-delivery bus between the receive datapath (master) and the
// APB/FIFO consumer (slave): held character, error flags and handshake.
interface uart_receive_datapath_if
    import uart_pkg::*;
#(
    parameter int DATA_MAX = UART_DATA_MAX
);
    logic [DATA_MAX-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                parity_err;
    logic                framing_err;
    logic                overrun_err;
    logic                err_clr;

    modport master (
        output rx_data, rx_valid, parity_err, framing_err, overrun_err,
        input  rx_ready, err_clr
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, framing_err, overrun_err,
        output rx_ready, err_clr
    );
endinterface

// File: rtl/uart_rx_holding_reg.sv
// One-entry holding register for received characters with valid/ready
// handshake, per-character error flags and a sticky overrun flag.
module uart_rx_holding_reg
    import uart_pkg::*;
#(
    parameter int DATA_MAX = UART_DATA_MAX
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                capture,
    input  logic [DATA_MAX-1:0] capture_data,
    input  logic                capture_perr,
    input  logic                capture_ferr,
    input  logic                rx_ready,
    input  logic                err_clr,
    output logic [DATA_MAX-1:0] rx_data,
    output logic                rx_valid,
    output logic                parity_err,
    output logic                framing_err,
    output logic                overrun_err
);

    logic load;
    logic drop;

    // A draining register accepts a new character in the same cycle.
    assign load = capture & (~rx_valid | rx_ready);
    assign drop = capture & rx_valid & ~rx_ready;

    always_ff @(posedge pclk) begin
        if (preset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (load) begin
                rx_data     <= capture_data;
                parity_err  <= capture_perr;
                framing_err <= capture_ferr;
                rx_valid    <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid    <= 1'b0;
            end

            if (drop) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_receive_datapath.sv
// UART receive datapath: frame counter, LSB-first assembly, parity/stop
// evaluation and hand-off of the finished character to the holding register.
module uart_receive_datapath
    import uart_pkg::*;
#(
    parameter int DATA_MAX = UART_DATA_MAX,
    parameter int CNT_W    = UART_CNT_W
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           uartn_rxd,
    input  logic                           sample_edge,
    input  logic                           receive_shift_en,
    input  logic                           receive_frame_counter_en,
    input  logic                           receive_frame_counter_clear,
    input  logic                           error_check,
    input  logic [1:0]                     char_len,
    input  logic                           parity_en,
    input  logic                           parity_odd,
    output logic                           receive_done,
    uart_receive_datapath_if.master        rx_bus
);

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    data_len;
    logic [CNT_W-1:0]    n_len;
    logic [DATA_MAX-1:0] shift_reg;
    logic [DATA_MAX-1:0] data_mask;
    logic                parity_bit;
    logic                stop_bit;
    logic                sample;
    logic                error_check_p1;
    logic                capture;
    logic                parity_calc;
    logic                perr;
    logic                ferr;

    assign data_len = CNT_W'(5) + CNT_W'(char_len);
    assign n_len    = CNT_W'(frame_len(char_len, parity_en));

    // Counter saturates at the frame length so extra strobes are ignored.
    assign sample = receive_frame_counter_en & sample_edge & ~receive_frame_counter_clear
                    & (cnt < n_len);

    always_comb begin
        cnt_next = cnt;
        if (receive_frame_counter_clear) begin
            cnt_next = '0;
        end else if (receive_frame_counter_en && (cnt < n_len)) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        data_mask = '0;
        for (int i = 0; i < DATA_MAX; i++) begin
            data_mask[i] = (CNT_W'(i) < data_len);
        end
    end

    // Stage p0: counting and bit sampling
    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt            <= '0;
            receive_done   <= 1'b0;
            shift_reg      <= '0;
            parity_bit     <= 1'b0;
            stop_bit       <= 1'b0;
            error_check_p1 <= 1'b0;
        end else begin
            cnt            <= cnt_next;
            receive_done   <= (cnt_next == n_len);
            error_check_p1 <= error_check;
            for (int i = 0; i < DATA_MAX; i++) begin
                if (sample && receive_shift_en && (cnt == CNT_W'(i)) && (cnt < data_len)) begin
                    shift_reg[i] <= uartn_rxd;
                end
            end
            if (sample && parity_en && (cnt == data_len)) begin
                parity_bit <= uartn_rxd;
            end
            if (sample && (cnt == n_len - CNT_W'(1))) begin
                stop_bit <= uartn_rxd;
            end
        end
    end

    // Stage p1: evaluate the completed frame on the rising edge of error_check
    assign capture     = error_check & ~error_check_p1;
    assign parity_calc = ^(shift_reg & data_mask) ^ parity_bit;
    assign perr        = parity_en & (parity_calc != parity_odd);
    assign ferr        = ~stop_bit;

    uart_rx_holding_reg #(
        .DATA_MAX (DATA_MAX)
    ) u_holding (
        .pclk         (pclk),
        .preset       (preset),
        .capture      (capture),
        .capture_data (shift_reg & data_mask),
        .capture_perr (perr),
        .capture_ferr (ferr),
        .rx_ready     (rx_bus.rx_ready),
        .err_clr      (rx_bus.err_clr),
        .rx_data      (rx_bus.rx_data),
        .rx_valid     (rx_bus.rx_valid),
        .parity_err   (rx_bus.parity_err),
        .framing_err  (rx_bus.framing_err),
        .overrun_err  (rx_bus.overrun_err)
    );

endmodule

// File: tb/tb_uart_receive_datapath.sv
// Self-checking bench for uart_receive_datapath: table of frames plus
// hand-written overrun, held-strobe, abort and reset sequences.
module tb_uart_receive_datapath;

    logic       pclk = 1'b0;
    logic       preset;
    logic       uartn_rxd;
    logic       sample_edge;
    logic       receive_shift_en;
    logic       receive_frame_counter_en;
    logic       receive_frame_counter_clear;
    logic       error_check;
    logic [1:0] char_len;
    logic       parity_en;
    logic       parity_odd;
    logic       receive_done;

    uart_receive_datapath_if #(.DATA_MAX(8)) rx_bus ();

    uart_receive_datapath #(.DATA_MAX(8), .CNT_W(4)) dut (
        .pclk                        (pclk),
        .preset                      (preset),
        .uartn_rxd                   (uartn_rxd),
        .sample_edge                 (sample_edge),
        .receive_shift_en            (receive_shift_en),
        .receive_frame_counter_en    (receive_frame_counter_en),
        .receive_frame_counter_clear (receive_frame_counter_clear),
        .error_check                 (error_check),
        .char_len                    (char_len),
        .parity_en                   (parity_en),
        .parity_odd                  (parity_odd),
        .receive_done                (receive_done),
        .rx_bus                      (rx_bus)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [1:0] cl;
        logic       pen;
        logic       podd;
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_frame(input logic [1:0] cl, input logic pen, input logic podd,
                               input logic [7:0] data, input logic pbit, input logic sbit);
        int d;
        int n;
        d = 5 + int'(cl);
        n = d + int'(pen) + 1;
        char_len = cl;
        parity_en = pen;
        parity_odd = podd;
        receive_frame_counter_clear = 1'b1;
        tick();
        receive_frame_counter_clear = 1'b0;
        receive_shift_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i < d) uartn_rxd = data[i];
            else if (pen && i == d) uartn_rxd = pbit;
            else uartn_rxd = sbit;
            sample_edge = 1'b1;
            receive_frame_counter_en = 1'b1;
            tick();
            sample_edge = 1'b0;
            receive_frame_counter_en = 1'b0;
            uartn_rxd = 1'b1;
            if (i == n - 2) chk("done_early", receive_done, 0);
            tick();
        end
        chk("done", receive_done, 1);
        receive_shift_en = 1'b0;
    endtask

    task automatic capture_pulse();
        error_check = 1'b1;
        tick();
        error_check = 1'b0;
    endtask

    task automatic end_frame();
        receive_frame_counter_clear = 1'b1;
        tick();
        receive_frame_counter_clear = 1'b0;
        chk("done_cleared", receive_done, 0);
    endtask

    task automatic check_pop(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb_empty actual=0 required=1", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_valid"}, rx_bus.rx_valid, 1);
            chk({name, "_data"}, rx_bus.rx_data, e.data);
            chk({name, "_perr"}, rx_bus.parity_err, e.perr);
            chk({name, "_ferr"}, rx_bus.framing_err, e.ferr);
        end
    endtask

    task automatic drain(input logic [7:0] held);
        rx_bus.rx_ready = 1'b1;
        tick();
        rx_bus.rx_ready = 1'b0;
        chk("drain_valid", rx_bus.rx_valid, 0);
        chk("drain_hold", rx_bus.rx_data, held);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b0};
        vecs[2] = '{2'b10, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[4] = '{2'b00, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0, 8'h15, 1'b0, 1'b1};
        vecs[5] = '{2'b01, 1'b1, 1'b1, 8'h2B, 1'b1, 1'b1, 8'h2B, 1'b0, 1'b0};
        vecs[6] = '{2'b01, 1'b1, 1'b1, 8'h2B, 1'b0, 1'b1, 8'h2B, 1'b1, 1'b0};

        preset = 1'b1;
        uartn_rxd = 1'b1;
        sample_edge = 1'b0;
        receive_shift_en = 1'b0;
        receive_frame_counter_en = 1'b0;
        receive_frame_counter_clear = 1'b0;
        error_check = 1'b0;
        char_len = 2'b11;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        rx_bus.rx_ready = 1'b0;
        rx_bus.err_clr = 1'b0;
        tick();
        tick();
        preset = 1'b0;
        chk("rst_data", rx_bus.rx_data, 0);
        chk("rst_valid", rx_bus.rx_valid, 0);
        chk("rst_perr", rx_bus.parity_err, 0);
        chk("rst_ferr", rx_bus.framing_err, 0);
        chk("rst_ovr", rx_bus.overrun_err, 0);
        chk("rst_done", receive_done, 0);

        for (int k = 0; k < 7; k++) begin
            sb_q.push_back('{data: vecs[k].exp_data, perr: vecs[k].exp_perr,
                             ferr: vecs[k].exp_ferr});
            drive_frame(vecs[k].cl, vecs[k].pen, vecs[k].podd, vecs[k].data,
                        vecs[k].pbit, vecs[k].sbit);
            capture_pulse();
            check_pop("vec");
            end_frame();
            drain(vecs[k].exp_data);
        end

        // Overrun: second frame arrives while first is still held
        sb_q.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        drive_frame(2'b11, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
        capture_pulse();
        check_pop("ovr_first");
        end_frame();
        drive_frame(2'b11, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
        capture_pulse();
        chk("ovr_hold_data", rx_bus.rx_data, 8'h5A);
        chk("ovr_hold_valid", rx_bus.rx_valid, 1);
        chk("ovr_set", rx_bus.overrun_err, 1);
        end_frame();
        rx_bus.err_clr = 1'b1;
        tick();
        rx_bus.err_clr = 1'b0;
        chk("ovr_clr", rx_bus.overrun_err, 0);
        drain(8'h5A);

        // error_check held for three cycles with the consumer ready
        sb_q.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b0});
        drive_frame(2'b11, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1);
        rx_bus.rx_ready = 1'b1;
        error_check = 1'b1;
        tick();
        check_pop("held_ec");
        tick();
        chk("held_ec_c2", rx_bus.rx_valid, 0);
        tick();
        chk("held_ec_c3", rx_bus.rx_valid, 0);
        error_check = 1'b0;
        rx_bus.rx_ready = 1'b0;
        end_frame();

        // Capture in the same cycle as the handshake keeps valid high
        sb_q.push_back('{data: 8'h33, perr: 1'b0, ferr: 1'b0});
        drive_frame(2'b11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1);
        capture_pulse();
        check_pop("swap_a");
        end_frame();
        sb_q.push_back('{data: 8'h44, perr: 1'b0, ferr: 1'b1});
        drive_frame(2'b11, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0);
        rx_bus.rx_ready = 1'b1;
        capture_pulse();
        rx_bus.rx_ready = 1'b0;
        check_pop("swap_b");
        chk("swap_no_ovr", rx_bus.overrun_err, 0);
        end_frame();
        drain(8'h44);

        // Abort after four data strobes, then a full frame
        char_len = 2'b11;
        parity_en = 1'b0;
        receive_shift_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uartn_rxd = 1'b1;
            sample_edge = 1'b1;
            receive_frame_counter_en = 1'b1;
            tick();
            sample_edge = 1'b0;
            receive_frame_counter_en = 1'b0;
            tick();
        end
        receive_shift_en = 1'b0;
        receive_frame_counter_clear = 1'b1;
        tick();
        receive_frame_counter_clear = 1'b0;
        chk("abort_done", receive_done, 0);
        chk("abort_valid", rx_bus.rx_valid, 0);
        sb_q.push_back('{data: 8'h96, perr: 1'b0, ferr: 1'b0});
        drive_frame(2'b11, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        capture_pulse();
        check_pop("abort_new");
        end_frame();

        // Reset with data held, overrun set and a completed uncaptured frame
        drive_frame(2'b11, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
        capture_pulse();
        chk("pre_rst_ovr", rx_bus.overrun_err, 1);
        chk("pre_rst_ferr", rx_bus.framing_err, 0);
        drive_frame(2'b00, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b1);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        chk("mid_rst_data", rx_bus.rx_data, 0);
        chk("mid_rst_valid", rx_bus.rx_valid, 0);
        chk("mid_rst_perr", rx_bus.parity_err, 0);
        chk("mid_rst_ferr", rx_bus.framing_err, 0);
        chk("mid_rst_ovr", rx_bus.overrun_err, 0);
        chk("mid_rst_done", receive_done, 0);

        chk("sb_left", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
